fir_xifu_scoreboard: RTL

- Issue/hazard controller for the XIFU FIR register file. It holds up to NB_INFLIGHT in-flight offloaded instructions: instruction id, destination register, and whether the instruction writes the register file.
- It gates issue into EX whenever any source operand (rs1, rs2, or rd read as accumulator op_c) or the destination collides with a pending write.
- It retires entries on writeback or on kill, and drives operand-forwarding selects into the register-file read path.

---
 rtl/fir_xifu_scoreboard.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fir_xifu_scoreboard.sv
// Issue/hazard scoreboard for the XIFU FIR register file: tracks in-flight offloaded
// instructions, stalls on pending writes, retires on WB/kill. Optional same-cycle WB bypass: FIR_XIFU_BYPASS_EN.
module fir_xifu_scoreboard #(
    parameter int NB_REGS     = 4,
    parameter int NB_INFLIGHT = 4,
    parameter int ID_W        = 4,
    localparam int REG_W      = (NB_REGS > 1) ? $clog2(NB_REGS) : 1,
    localparam int SLOT_W     = $clog2(NB_INFLIGHT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [ID_W-1:0]    issue_id_i,
    input  logic [REG_W-1:0]   issue_rs1_i,
    input  logic [REG_W-1:0]   issue_rs2_i,
    input  logic [REG_W-1:0]   issue_rd_i,
    input  logic               issue_we_i,
    input  logic               kill_valid_i,
    input  logic [ID_W-1:0]    kill_id_i,
    input  logic               wb_valid_i,
    input  logic [ID_W-1:0]    wb_id_i,
    input  logic [REG_W-1:0]   wb_rd_i,
    output logic               fwd_a_o,
    output logic               fwd_b_o,
    output logic               fwd_c_o,
    output logic [NB_REGS-1:0] pending_o,
    output logic               full_o,
    output logic               err_o
);

    logic [NB_INFLIGHT-1:0] slot_valid;
    logic [NB_INFLIGHT-1:0] slot_we;
    logic [ID_W-1:0]        slot_id [NB_INFLIGHT];
    logic [REG_W-1:0]       slot_rd [NB_INFLIGHT];

    logic [NB_INFLIGHT-1:0] wb_match;
    logic [NB_INFLIGHT-1:0] kill_match;
    logic                   dup_hit;
    logic                   wb_rd_bad;
    logic                   wb_miss;
    logic [NB_REGS-1:0]     pend_unres;
    logic                   hazard;
    logic                   accept;
    logic [SLOT_W-1:0]      alloc_idx;
    logic                   alloc_found;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pending_o  = '0;
        wb_match   = '0;
        kill_match = '0;
        dup_hit    = 1'b0;
        wb_rd_bad  = 1'b0;
        for (int i = 0; i < NB_INFLIGHT; i++) begin
            if (slot_valid[i]) begin
                if (slot_we[i])
                    pending_o[slot_rd[i]] = 1'b1;
                wb_match[i]   = wb_valid_i && (slot_id[i] == wb_id_i);
                kill_match[i] = kill_valid_i && (slot_id[i] == kill_id_i);
                if (slot_id[i] == issue_id_i)
                    dup_hit = 1'b1;
                if (wb_match[i] && (slot_rd[i] != wb_rd_i))
                    wb_rd_bad = 1'b1;
            end
        end
        wb_miss = wb_valid_i && !(|wb_match);
    end

    assign full_o = &slot_valid;

`ifdef FIR_XIFU_BYPASS_EN
    // A register stays blocked if any pending writer other than the one retiring right now targets it.
    always_comb begin
        pend_unres = '0;
        for (int i = 0; i < NB_INFLIGHT; i++) begin
            if (slot_valid[i] && slot_we[i] && !(wb_match[i] && (slot_rd[i] == wb_rd_i)))
                pend_unres[slot_rd[i]] = 1'b1;
        end
    end

    assign fwd_a_o = accept && pending_o[issue_rs1_i] && !pend_unres[issue_rs1_i];
    assign fwd_b_o = accept && pending_o[issue_rs2_i] && !pend_unres[issue_rs2_i];
    assign fwd_c_o = accept && pending_o[issue_rd_i]  && !pend_unres[issue_rd_i];
`else
    assign pend_unres = pending_o;
    assign fwd_a_o    = 1'b0;
    assign fwd_b_o    = 1'b0;
    assign fwd_c_o    = 1'b0;
`endif

    assign hazard = issue_valid_i &&
                    (pend_unres[issue_rs1_i] || pend_unres[issue_rs2_i] || pend_unres[issue_rd_i]);
    assign issue_ready_o = !rst_i && !full_o && !hazard;
    assign accept        = issue_valid_i && issue_ready_o;

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NB_INFLIGHT; i++) begin
            if (!slot_valid[i] && !alloc_found) begin
                alloc_idx   = SLOT_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    // NOTE: the slot arrays are small control state, so they are reset along with the valid bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid <= '0;
            slot_we    <= '0;
            err_o      <= 1'b0;
            for (int i = 0; i < NB_INFLIGHT; i++) begin
                slot_id[i] <= '0;
                slot_rd[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let retire and allocate act on the same edge without ordering races.
            for (int i = 0; i < NB_INFLIGHT; i++) begin
                if (wb_match[i] || kill_match[i])
                    slot_valid[i] <= 1'b0;
                if (accept && (alloc_idx == SLOT_W'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_id[i]    <= issue_id_i;
                    slot_rd[i]    <= issue_rd_i;
                    slot_we[i]    <= issue_we_i;
                end
            end
            if (wb_miss || wb_rd_bad || (issue_valid_i && dup_hit))
                err_o <= 1'b1;
        end
    end

endmodule
